textinput_feeder: RTL
=====================

TEXTINPUT_FEEDER -- requirements
Module: textinput_feeder

Interface
REQ-001 CHAR_GAP, 25000, idle clk25 cycles between a key acknowledge and presenting the next key (1 ms).
REQ-002 CR_GAP, 2500000, idle clk25 cycles after a CR key is acknowledged (100 ms; monitor/BASIC line processing).
REQ-003 clk25  in  1  single system clock, 25 MHz.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high while a text file download is active (already qualified by non-zero index).
REQ-006 ioctl_wr  in  1  one-cycle strobe; the byte on ioctl_dout is valid.
REQ-007 ioctl_addr  in  13  byte address of the download byte.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 kbd_rd  in  1  one-cycle strobe; the CPU read the PIA keyboard data register.
REQ-010 kbd_data  out  8  ASCII key code with bit 7 forced to 1.
REQ-011 kbd_valid  out  1  key available (drives the PIA CA1 strobe/flag).
REQ-012 busy  out  1  high during LOAD or playback.

Function
REQ-013 Internal buffer: 8192 x 8 single-port RAM with a 1-cycle registered read; the write port is used only in LOAD.
REQ-014 States: IDLE, LOAD, FETCH, XLATE, PRESENT, GAP.
REQ-015 IDLE -> LOAD when ioctl_download rises; clear len to 0.
REQ-016 LOAD: on ioctl_wr, write the byte at ioctl_addr and set len = max(len, ioctl_addr+1) (14-bit, no wrap).
REQ-017 LOAD: on ioctl_download falling, go to FETCH with rd_ptr=0 if len>0, else go to IDLE.
REQ-018 FETCH: issue a RAM read at rd_ptr; the data is usable in XLATE on the next cycle.
REQ-019 XLATE mapping:
  - 0x61-0x7A -> subtract 0x20.
  - 0x09 -> 0x20.
  - 0x0D -> 0x0D.
  - 0x0A -> 0x0D, or skipped if the previous emitted byte was 0x0D (CRLF collapses to one CR).
  - Bytes 0x00-0x1F not listed above, 0x7F and 0x80-0xFF -> skipped.
REQ-020 XLATE on a skip: rd_ptr+1; go to FETCH, or to IDLE if rd_ptr+1 == len.
REQ-021 XLATE on an emit: load kbd_data = {1'b1, code[6:0]}, assert kbd_valid, go to PRESENT.
REQ-022 PRESENT: hold kbd_data/kbd_valid stable until kbd_rd.
REQ-023 PRESENT on kbd_rd: kbd_valid=0 in the next cycle; load the gap counter with CR_GAP if code was 0x0D, else CHAR_GAP; rd_ptr+1; go to GAP.
REQ-024 GAP: decrement the counter; at 0, go to FETCH, or to IDLE if rd_ptr == len.
REQ-025 kbd_rd outside PRESENT is ignored.
REQ-026 A rise of ioctl_download in any playback state aborts playback: kbd_valid=0 on the next cycle, go to LOAD, clear len.
REQ-027 Simultaneous kbd_rd and ioctl_download rise: the abort takes priority.
REQ-028 busy = state != IDLE.
REQ-029 The "previous emitted was CR" flag clears on entry to LOAD.
REQ-030 Latency: first kbd_valid at 3 cycles after ioctl_download falls (LOAD->FETCH->XLATE->PRESENT), when the first byte is emittable.

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, kbd_valid=0, kbd_data=0x00, busy=0, len=0, rd_ptr=0, gap counter=0, CR flag=0.
REQ-032 RAM contents are not reset; playback never starts without a new LOAD.
REQ-033 Reset asserted mid-playback or mid-LOAD abandons the operation with no further kbd_valid.

Structure
REQ-034 Package apple1_pkg holds: the state enum, ASCII constants (CR, LF, TAB, DEL), and the buffer depth/address width (8192/13).
REQ-035 One sub-module: textinput_ram (8192x8, synchronous write, registered read).
REQ-036 XLATE mapping is a function in apple1_pkg.

Verification
REQ-037 Download "ab\r\n" (4 bytes), pulse kbd_rd on each key -> kbd_data 0xC1, 0xC2, 0x8D, then IDLE; only one CR emitted.
REQ-038 Download "X\n" -> 0xD8, then 0x8D after CHAR_GAP cycles; busy falls CR_GAP cycles after the CR acknowledge.
REQ-039 Download {0x01, 0xFF, 0x09, 0x41} -> keys 0xA0 then 0xC1 only.
REQ-040 Zero-byte download -> busy returns to 0 one cycle after ioctl_download falls; kbd_valid never asserts.
REQ-041 New download started while kbd_valid=1 with kbd_rd in the same cycle -> kbd_valid=0 next cycle, state LOAD, new file plays from byte 0.
REQ-042 rst_n pulsed low during GAP -> all outputs at reset values immediately; no key after rst_n releases.

Source files
------------

// File: rtl/apple1_pkg.sv
// Shared types and constants for the Apple-1 text-input feeder.
// This includes the feeder FSM state, the ASCII codes, the buffer geometry and the key translation.
package apple1_pkg;

  localparam int BUF_DEPTH = 8192;
  localparam int ADDR_W    = 13;
  localparam int LEN_W     = 14;
  localparam int GAP_W     = 22;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_XLATE,
    S_PRESENT,
    S_GAP
  } feeder_state_e;

  typedef struct packed {
    logic       emit;
    logic [7:0] code;
  } xlate_t;

  // prev_cr lets an LF that follows a CR collapse away, so CRLF files give a single return.
  function automatic xlate_t xlate_byte(input logic [7:0] b, input logic prev_cr);
    xlate_t r;
    r.emit = 1'b0;
    r.code = 8'h00;
    if (b >= 8'h61 && b <= 8'h7A) begin
      r.emit = 1'b1;
      r.code = b - 8'h20;
    end else if (b == ASCII_TAB) begin
      r.emit = 1'b1;
      r.code = 8'h20;
    end else if (b == ASCII_CR) begin
      r.emit = 1'b1;
      r.code = ASCII_CR;
    end else if (b == ASCII_LF) begin
      r.emit = !prev_cr;
      r.code = ASCII_CR;
    end else if (b >= 8'h20 && b < ASCII_DEL) begin
      r.emit = 1'b1;
      r.code = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/textinput_ram.sv
// Text buffer for the feeder: 8192 x 8 single-port RAM.
// Writes are synchronous, and a read returns its data on the next cycle.
module textinput_ram
  import apple1_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:BUF_DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/textinput_feeder.sv
// Buffers a downloaded text file and replays it as Apple-1 keyboard keys.
// Each key waits for a CPU read, and after each read the next key is held back by a pacing gap.
module textinput_feeder
  import apple1_pkg::*;
#(
  parameter int CHAR_GAP = 25000,
  parameter int CR_GAP   = 2500000
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              kbd_rd,
  output logic [7:0]        kbd_data,
  output logic              kbd_valid,
  output logic              busy
);

  // Key handshake: kbd_valid rises together with a stable kbd_data.
  // Both hold until a kbd_rd strobe, and kbd_valid drops on the cycle after that strobe.
  feeder_state_e    state, state_next;
  logic [LEN_W-1:0] len, len_next;
  logic [LEN_W-1:0] rd_ptr, rd_ptr_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic             prev_cr, cr_next;
  logic             valid_next;
  logic [7:0]       data_next;
  logic             dl_prev;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  xlate_t            xl;

  logic             dl_rise, dl_fall;
  logic [LEN_W-1:0] wr_end, ptr_inc;

  assign dl_rise = ioctl_download & ~dl_prev;
  assign dl_fall = ~ioctl_download & dl_prev;
  assign wr_end  = {1'b0, ioctl_addr} + LEN_W'(1);
  assign ptr_inc = rd_ptr + LEN_W'(1);
  assign busy    = (state != S_IDLE);

  textinput_ram u_ram (
    .clk   (clk25),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ioctl_dout),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      rd_ptr    <= '0;
      gap_cnt   <= '0;
      prev_cr   <= 1'b0;
      kbd_valid <= 1'b0;
      kbd_data  <= 8'h00;
      dl_prev   <= 1'b0;
    end else begin
      state     <= state_next;
      len       <= len_next;
      rd_ptr    <= rd_ptr_next;
      gap_cnt   <= gap_next;
      prev_cr   <= cr_next;
      kbd_valid <= valid_next;
      kbd_data  <= data_next;
      dl_prev   <= ioctl_download;
    end
  end

  always_comb begin
    state_next  = state;
    len_next    = len;
    rd_ptr_next = rd_ptr;
    gap_next    = gap_cnt;
    cr_next     = prev_cr;
    valid_next  = kbd_valid;
    data_next   = kbd_data;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = rd_ptr[ADDR_W-1:0];
    xl          = xlate_byte(ram_rdata, prev_cr);

    // A new download pre-empts everything, including a kbd_rd in the same cycle.
    if (dl_rise && state != S_LOAD) begin
      state_next = S_LOAD;
      len_next   = '0;
      valid_next = 1'b0;
      cr_next    = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_LOAD: begin
          ram_addr = ioctl_addr;
          if (dl_fall) begin
            rd_ptr_next = '0;
            state_next  = (len != '0) ? S_FETCH : S_IDLE;
          end else if (ioctl_wr) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
            if (wr_end > len) len_next = wr_end;
          end
        end
        S_FETCH: begin
          ram_en     = 1'b1;
          state_next = S_XLATE;
        end
        S_XLATE: begin
          if (xl.emit) begin
            data_next  = {1'b1, xl.code[6:0]};
            valid_next = 1'b1;
            cr_next    = (xl.code == ASCII_CR);
            state_next = S_PRESENT;
          end else begin
            rd_ptr_next = ptr_inc;
            state_next  = (ptr_inc == len) ? S_IDLE : S_FETCH;
          end
        end
        S_PRESENT: begin
          if (kbd_rd) begin
            valid_next  = 1'b0;
            gap_next    = prev_cr ? GAP_W'(CR_GAP) : GAP_W'(CHAR_GAP);
            rd_ptr_next = ptr_inc;
            state_next  = S_GAP;
          end
        end
        S_GAP: begin
          // The exit happens on the cycle the counter would reach zero, so the gap lasts exactly the loaded count.
          if (gap_cnt <= GAP_W'(1)) begin
            gap_next   = '0;
            state_next = (rd_ptr == len) ? S_IDLE : S_FETCH;
          end else begin
            gap_next = gap_cnt - GAP_W'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule
